// File: rtl/shift_reg_uni.sv
// Universal shift register: hold, parallel load, shift left, shift right.
// Emits a one-cycle done pulse after every WIDTH enabled shifts since the last load or reset.
module shift_reg_uni #(
    parameter int               WIDTH     = 8,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             e,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] D,
    input  logic             sin,
    output logic [WIDTH-1:0] Q,
    output logic [WIDTH-1:0] QNOT,
    output logic             sout,
    output logic             done
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        OP_HOLD  = 2'b00,
        OP_LOAD  = 2'b01,
        OP_SHL   = 2'b10,
        OP_SHR   = 2'b11
    } op_t;

    op_t            op;
    logic [CW-1:0]  cnt;
    logic [CW-1:0]  cnt_next;
    logic [WIDTH-1:0] q_next;
    logic           sout_next;
    logic           done_next;
    logic           shifting;

    assign op       = op_t'(mode);
    assign QNOT     = ~Q;
    assign shifting = e && (op == OP_SHL || op == OP_SHR);

    always_comb begin
        q_next    = Q;
        sout_next = sout;
        cnt_next  = cnt;
        done_next = 1'b0;
        if (e) begin
            case (op)
                OP_LOAD: begin
                    q_next    = D;
                    sout_next = 1'b0;
                    cnt_next  = '0;
                end
                OP_SHL: begin
                    q_next    = {Q[WIDTH-2:0], sin};
                    sout_next = Q[WIDTH-1];
                end
                OP_SHR: begin
                    q_next    = {sin, Q[WIDTH-1:1]};
                    sout_next = Q[0];
                end
                default: ;
            endcase
        end
        // Direction is irrelevant to the count; both shifts advance the same counter.
        if (shifting) begin
            if (cnt == CW'(WIDTH - 1)) begin
                cnt_next  = '0;
                done_next = 1'b1;
            end else begin
                cnt_next = cnt + CW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            Q    <= RESET_VAL;
            sout <= 1'b0;
            done <= 1'b0;
            cnt  <= '0;
        end else begin
            Q    <= q_next;
            sout <= sout_next;
            done <= done_next;
            cnt  <= cnt_next;
        end
    end

endmodule

// File: tb/tb_shift_reg_uni.sv
// Directed bench for shift_reg_uni (WIDTH=8): stimulus pushes expected results into a
// scoreboard queue; a monitor pops one entry after each clock edge and compares.
module tb_shift_reg_uni;

    logic       clk;
    logic       rst;
    logic       e;
    logic [1:0] mode;
    logic [7:0] D;
    logic       sin;
    logic [7:0] Q;
    logic [7:0] QNOT;
    logic       sout;
    logic       done;

    int total = 0;
    int bad   = 0;
    int step_id = 0;

    typedef struct {
        int         id;
        logic [7:0] q;
        logic       sout;
        logic       done;
    } exp_t;

    exp_t sb[$];

    shift_reg_uni #(.WIDTH(8), .RESET_VAL(8'h00)) dut (
        .clk (clk),
        .rst (rst),
        .e   (e),
        .mode(mode),
        .D   (D),
        .sin (sin),
        .Q   (Q),
        .QNOT(QNOT),
        .sout(sout),
        .done(done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step(input logic r, input logic en, input logic [1:0] m,
                        input logic [7:0] d, input logic s,
                        input logic [7:0] xq, input logic xs, input logic xd);
        exp_t x;
        @(negedge clk);
        rst  = r;
        e    = en;
        mode = m;
        D    = d;
        sin  = s;
        step_id++;
        x.id   = step_id;
        x.q    = xq;
        x.sout = xs;
        x.done = xd;
        sb.push_back(x);
    endtask

    initial begin : monitor
        exp_t x;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                x = sb.pop_front();
                total++;
                if (Q !== x.q) begin
                    bad++;
                    $display("FAIL q step%0d: got %h want %h", x.id, Q, x.q);
                end
                total++;
                if (QNOT !== ~x.q) begin
                    bad++;
                    $display("FAIL qnot step%0d: got %h want %h", x.id, QNOT, ~x.q);
                end
                total++;
                if (sout !== x.sout) begin
                    bad++;
                    $display("FAIL sout step%0d: got %b want %b", x.id, sout, x.sout);
                end
                total++;
                if (done !== x.done) begin
                    bad++;
                    $display("FAIL done step%0d: got %b want %b", x.id, done, x.done);
                end
            end
        end
    end

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        rst = 1'b1; e = 1'b0; mode = 2'b00; D = '0; sin = 1'b0;

        // reset beats enable and load
        step(0, 1, 2'b01, 8'hFF, 0, 8'h00, 0, 0);
        // load, then disabled cycles must hold
        step(1, 1, 2'b01, 8'hA5, 0, 8'hA5, 0, 0);
        step(1, 0, 2'b01, 8'h00, 0, 8'hA5, 0, 0);
        step(1, 0, 2'b01, 8'h00, 0, 8'hA5, 0, 0);
        step(1, 0, 2'b01, 8'h00, 0, 8'hA5, 0, 0);
        // shift left once
        step(1, 1, 2'b10, 8'h00, 1, 8'h4B, 1, 0);

        // full shift-right sequence from 81
        step(1, 1, 2'b01, 8'h81, 0, 8'h81, 0, 0);
        step(1, 1, 2'b11, 8'h00, 0, 8'h40, 1, 0);
        step(1, 1, 2'b11, 8'h00, 0, 8'h20, 0, 0);
        step(1, 1, 2'b11, 8'h00, 0, 8'h10, 0, 0);
        step(1, 1, 2'b11, 8'h00, 0, 8'h08, 0, 0);
        step(1, 1, 2'b11, 8'h00, 0, 8'h04, 0, 0);
        step(1, 1, 2'b11, 8'h00, 0, 8'h02, 0, 0);
        step(1, 1, 2'b11, 8'h00, 0, 8'h01, 0, 0);
        step(1, 1, 2'b11, 8'h00, 0, 8'h00, 1, 1);
        step(1, 1, 2'b00, 8'h00, 0, 8'h00, 1, 0);

        // reset mid-sequence discards partial count
        step(1, 1, 2'b01, 8'hFF, 0, 8'hFF, 0, 0);
        step(1, 1, 2'b10, 8'h00, 0, 8'hFE, 1, 0);
        step(1, 1, 2'b10, 8'h00, 0, 8'hFC, 1, 0);
        step(1, 1, 2'b10, 8'h00, 0, 8'hF8, 1, 0);
        step(1, 1, 2'b10, 8'h00, 0, 8'hF0, 1, 0);
        step(1, 1, 2'b10, 8'h00, 0, 8'hE0, 1, 0);
        step(0, 1, 2'b10, 8'h00, 1, 8'h00, 0, 0);
        step(1, 1, 2'b10, 8'h00, 1, 8'h01, 0, 0);
        step(1, 1, 2'b10, 8'h00, 1, 8'h03, 0, 0);
        step(1, 1, 2'b10, 8'h00, 1, 8'h07, 0, 0);
        step(1, 1, 2'b10, 8'h00, 1, 8'h0F, 0, 0);
        step(1, 1, 2'b10, 8'h00, 1, 8'h1F, 0, 0);
        step(1, 1, 2'b10, 8'h00, 1, 8'h3F, 0, 0);
        step(1, 1, 2'b10, 8'h00, 1, 8'h7F, 0, 0);
        step(1, 1, 2'b10, 8'h00, 1, 8'hFF, 0, 1);

        // gapped shifts with direction changes: one done after 8th enabled shift
        step(1, 1, 2'b01, 8'h00, 0, 8'h00, 0, 0);
        step(1, 1, 2'b10, 8'h00, 1, 8'h01, 0, 0);
        step(1, 0, 2'b10, 8'h00, 1, 8'h01, 0, 0);
        step(1, 1, 2'b11, 8'h00, 0, 8'h00, 1, 0);
        step(1, 1, 2'b00, 8'h00, 0, 8'h00, 1, 0);
        step(1, 1, 2'b10, 8'h00, 1, 8'h01, 0, 0);
        step(1, 1, 2'b10, 8'h00, 1, 8'h03, 0, 0);
        step(1, 0, 2'b10, 8'h00, 1, 8'h03, 0, 0);
        step(1, 1, 2'b11, 8'h00, 1, 8'h81, 1, 0);
        step(1, 1, 2'b00, 8'h00, 1, 8'h81, 1, 0);
        step(1, 1, 2'b10, 8'h00, 0, 8'h02, 1, 0);
        step(1, 1, 2'b11, 8'h00, 0, 8'h01, 0, 0);
        step(1, 1, 2'b10, 8'h00, 1, 8'h03, 0, 1);
        step(1, 0, 2'b10, 8'h00, 1, 8'h03, 0, 0);

        // reset beats a disabled shift request
        step(0, 0, 2'b10, 8'hFF, 1, 8'h00, 0, 0);

        @(negedge clk);
        rst = 1'b1; e = 1'b0; mode = 2'b00;
        for (int i = 0; i < 10 && sb.size() > 0; i++) @(posedge clk);
        #2;
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL drain: got %0d pending want 0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/shift_reg_uni.md
SHIFT_REG_UNI -- requirements
Module: shift_reg_uni

Interface
REQ-001 The block SHALL run on one clock; reset SHALL be synchronous and active-low.
REQ-002 Parameter WIDTH, default 8, SHALL set the register width in bits; legal range 2..64.
REQ-003 Parameter RESET_VAL, default 0, SHALL set the WIDTH-bit value loaded into Q on reset.
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 rst  input  1  synchronous active-low reset, sampled on the clk rising edge.
REQ-006 e  input  1  clock enable; 0 freezes all state.
REQ-007 mode  input  2  operation select: 00 hold, 01 parallel load, 10 shift left, 11 shift right.
REQ-008 D  input  WIDTH  parallel load data.
REQ-009 sin  input  1  serial input bit for shifts.
REQ-010 Q  output  WIDTH  register contents.
REQ-011 QNOT  output  WIDTH  bitwise complement of Q.
REQ-012 sout  output  1  registered copy of the bit shifted out on the last shift.
REQ-013 done  output  1  one-cycle pulse marking completion of WIDTH shifts.

Function
REQ-014 All state SHALL update only on the clk rising edge; there SHALL be no latches and no asynchronous paths.
REQ-015 QNOT SHALL equal ~Q combinationally at all times, including during reset.
REQ-016 The shift counter SHALL be $clog2(WIDTH+1) bits wide and internal.
REQ-017 On rst=0, reset SHALL take priority over e and mode.
REQ-018 With rst=1 and e=0, Q, sout, and the counter SHALL hold, and done SHALL be 0 on the next cycle.
REQ-019 With rst=1, e=1, mode=00, Q, sout, and the counter SHALL hold, and done SHALL be 0.
REQ-020 With rst=1, e=1, mode=01: Q SHALL load D, the counter SHALL clear to 0, sout SHALL clear to 0, and done SHALL be 0.
REQ-021 With rst=1, e=1, mode=10: Q SHALL become {Q[WIDTH-2:0], sin} and sout SHALL become the old Q[WIDTH-1].
REQ-022 With rst=1, e=1, mode=11: Q SHALL become {sin, Q[WIDTH-1:1]} and sout SHALL become the old Q[0].
REQ-023 Each enabled shift (mode 10 or 11) SHALL increment the counter.
REQ-024 Changing shift direction SHALL NOT clear the counter.
REQ-025 On the edge that performs the WIDTH-th shift since the last load or reset, the counter SHALL wrap to 0 and done SHALL be 1 for exactly that following cycle.
REQ-026 done SHALL be 0 in every cycle other than the one defined in REQ-025; back-to-back shifts SHALL give one done pulse per WIDTH shifts.
REQ-027 Disabled cycles (e=0) and hold cycles (mode=00) between shifts SHALL NOT reset or advance the counter.
REQ-028 Output latency SHALL be one clk cycle from the sampled inputs to Q, sout, and done.

Reset
REQ-029 On a clk edge with rst=0, the block SHALL set Q=RESET_VAL, sout=0, done=0, and counter=0, regardless of e, mode, D, and sin.
REQ-030 Reset asserted mid-sequence SHALL discard the partial shift count; WIDTH further shifts SHALL be required for the next done.
REQ-031 Before the first rst=0 edge, outputs SHALL be undefined; benches SHALL apply reset before checking any output.

Verification (WIDTH=8, RESET_VAL=0)
REQ-032 Reset beats enable: rst=0, e=1, mode=01, D=FF, one edge -> Q=00, QNOT=FF, sout=0, done=0.
REQ-033 Load then disable: load D=A5 -> Q=A5, QNOT=5A. Then e=0, mode=01, D=00 for 3 edges -> Q stays A5.
REQ-034 Shift left: from Q=A5, mode=10, sin=1, one edge -> Q=4B, sout=1, done=0.
REQ-035 Full shift-right sequence: load 81, then 8 edges with mode=11, sin=0 -> Q=00 after edge 8; done=1 only in the cycle after edge 8; sout=1 after edge 1.
REQ-036 Reset mid-sequence: 5 shifts, then rst=0 for one edge -> Q=00, done=0. Then 7 shifts -> no done; the 8th shift -> done=1.
REQ-037 Gapped shifts: 8 shifts separated by e=0 and mode=00 cycles -> exactly one done pulse, after the 8th enabled shift.
